// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, taken-branch squash and memory-busy freeze.
// Controls are combinational from registered state plus current inputs; stall_cnt saturates.
module hazard_ctrl #(
  parameter int unsigned LOAD_BUBBLES = 1,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             idex_mread,
  input  logic [4:0]       idex_rt,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             ifid_use_rt,
  input  logic             branch_taken,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_flush,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned CW       = 3;
  localparam logic [CW-1:0] LB_INIT = CW'(LOAD_BUBBLES - 1);
  localparam logic [CW-1:0] FL_INIT = CW'(FLUSH_CYCLES - 1);
  localparam bit          LB_MULTI = (LOAD_BUBBLES > 1);
  localparam bit          FL_MULTI = (FLUSH_CYCLES > 1);

  typedef enum logic [1:0] {S_RUN, S_LSTALL, S_FLUSH, S_MEM_WAIT} state_t;
  typedef enum logic [1:0] {A_NONE, A_HOLD, A_FLUSH, A_BUBBLE} act_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  act_t          act;
  logic          load_use;

  assign load_use = idex_mread && (idex_rt != 5'd0) &&
                    ((idex_rt == ifid_rs) || (ifid_use_rt && (idex_rt == ifid_rt)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Event priority: mem_busy > branch_taken > load_use; MEM_WAIT re-evaluates as RUN once released.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    act       = A_NONE;
    if (mem_busy) begin
      act       = A_HOLD;
      state_nxt = S_MEM_WAIT;
    end else if (branch_taken && (state != S_FLUSH)) begin
      act = A_FLUSH;
      if (FL_MULTI) begin
        state_nxt = S_FLUSH;
        cnt_nxt   = FL_INIT;
      end else begin
        state_nxt = S_RUN;
      end
    end else begin
      case (state)
        S_LSTALL: begin
          act     = A_BUBBLE;
          cnt_nxt = cnt - CW'(1);
          if (cnt == CW'(1)) state_nxt = S_RUN;
        end
        S_FLUSH: begin
          act     = A_FLUSH;
          cnt_nxt = cnt - CW'(1);
          if (cnt == CW'(1)) state_nxt = S_RUN;
        end
        default: begin
          state_nxt = S_RUN;
          if (load_use) begin
            act = A_BUBBLE;
            if (LB_MULTI) begin
              state_nxt = S_LSTALL;
              cnt_nxt   = LB_INIT;
            end
          end
        end
      endcase
    end
  end

  // Flushes never clear the matching write enable; the consumer ignores it.
  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    idex_write = 1'b1;
    idex_flush = 1'b0;
    if (!rst) begin
      case (act)
        A_HOLD: begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_write = 1'b0;
        end
        A_FLUSH: begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end
        A_BUBBLE: begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_flush = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (!pc_write && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
